// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues instruction memory reads, registers the
// returned word for decode, and handles stalls and branch/jump redirects.
// A redirect that arrives while a read is outstanding parks the target and
// waits in FLUSH for the stale response to drain.
// Optional feature: define FETCH_CNT_EN to build the delivered-instruction
// counter; without it o_fetch_count is tied to zero.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_instr;
  logic [31:0] w_instr_next;
  logic [31:0] r_instr_pc;
  logic [31:0] w_instr_pc_next;
  logic        r_instr_valid;
  logic        w_instr_valid_next;
  logic [31:0] r_saved_pc;
  logic [31:0] w_saved_pc_next;
  logic        w_req;
  logic        w_ack;

  // Read request: in REQ only ask for a new word when the output slot is free
  // or about to be consumed, so a stalled instruction is never overwritten.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      IDLE:    w_req = 1'b0;
      REQ:     w_req = !r_instr_valid || !i_stall;
      FLUSH:   w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  // An ack only counts when a request is actually being made.
  assign w_ack = w_req & i_imem_ack;

  // Next-state and datapath updates; redirect outranks ack, stall and consumption.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_instr_next       = r_instr;
    w_instr_pc_next    = r_instr_pc;
    w_instr_valid_next = r_instr_valid;
    w_saved_pc_next    = r_saved_pc;
    case (r_state)
      IDLE: begin
        w_state_next = REQ;
        if (i_redirect_valid) begin
          w_pc_next          = i_redirect_pc;
          w_instr_valid_next = 1'b0;
        end
      end
      REQ: begin
        if (i_redirect_valid) begin
          w_instr_valid_next = 1'b0;
          if (!w_req || i_imem_ack) begin
            w_pc_next = i_redirect_pc;
          end else begin
            w_saved_pc_next = i_redirect_pc;
            w_state_next    = FLUSH;
          end
        end else if (w_ack) begin
          w_instr_next       = i_imem_rdata;
          w_instr_pc_next    = r_pc;
          w_instr_valid_next = 1'b1;
          w_pc_next          = r_pc + 32'd4;
        end else if (r_instr_valid && !i_stall) begin
          w_instr_valid_next = 1'b0;
        end
      end
      FLUSH: begin
        if (i_redirect_valid) begin
          w_instr_valid_next = 1'b0;
        end else if (r_instr_valid && !i_stall) begin
          w_instr_valid_next = 1'b0;
        end
        if (w_ack) begin
          w_pc_next    = i_redirect_valid ? i_redirect_pc : r_saved_pc;
          w_state_next = REQ;
        end else if (i_redirect_valid) begin
          w_saved_pc_next = i_redirect_pc;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: fetch pointer, delivered instruction, parked target.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_saved_pc    <= 32'd0;
    end else begin
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_instr_pc    <= w_instr_pc_next;
      r_instr_valid <= w_instr_valid_next;
      r_saved_pc    <= w_saved_pc_next;
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] r_fetch_count;
  logic        w_consume;

  assign w_consume = r_instr_valid & !i_stall & !i_redirect_valid;

  // Count each instruction decode actually takes; squashed ones are not counted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count <= 32'd0;
    end else if (w_consume) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`else
  assign o_fetch_count = 32'd0;
`endif

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port stall  input  1  SHALL mean the decode stage cannot accept instr this cycle.
REQ-005 Port redirect_valid  input  1  SHALL mean a taken branch or jump target is presented this cycle.
REQ-006 Port redirect_pc  input  32  SHALL be the branch/jump target, sampled when redirect_valid=1.
REQ-007 Port imem_req  output  1  SHALL be the instruction memory read request.
REQ-008 Port imem_addr  output  32  SHALL be the read address, equal to the internal pc register.
REQ-009 Port imem_ack  input  1  SHALL mean imem_rdata is valid for the current request this cycle.
REQ-010 Port imem_rdata  input  32  SHALL be the returned instruction word.
REQ-011 Port instr  output  32  SHALL be the registered instruction for decode.
REQ-012 Port instr_pc  output  32  SHALL be the address instr was fetched from.
REQ-013 Port instr_valid  output  1  SHALL mean instr/instr_pc hold a deliverable instruction.
REQ-014 Port fetch_count  output  32  SHALL be the delivered-instruction count (see Configuration).

Function
REQ-015 States SHALL be IDLE, REQ and FLUSH; IDLE SHALL go to REQ unconditionally on the next edge.
REQ-016 In REQ, imem_req SHALL be combinationally (!instr_valid || !stall); in IDLE it SHALL be 0; in FLUSH it SHALL be 1.
REQ-017 Once imem_req is high without imem_ack, imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-018 imem_ack SHALL be ignored whenever imem_req is 0.
REQ-019 REQ, imem_req&imem_ack, no redirect: next edge instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-020 Latency: the acked instruction SHALL appear on instr one cycle after the ack.
REQ-021 Consumption: instr_valid&!stall with no accepted ack and no redirect SHALL clear instr_valid next edge.
REQ-022 instr_valid&stall SHALL hold instr, instr_pc and instr_valid unchanged.
REQ-023 redirect_valid SHALL have priority over ack, stall and consumption, and SHALL clear instr_valid on that edge.
REQ-024 Redirect in REQ with imem_req=0, or with imem_ack=1: pc<=redirect_pc, returned data discarded, stay REQ.
REQ-025 Redirect in REQ with imem_req=1, imem_ack=0: save redirect_pc, enter FLUSH, pc unchanged.
REQ-026 FLUSH: on imem_ack discard data, pc<=saved target, return to REQ; a new redirect in FLUSH SHALL overwrite the saved target (latest wins).
REQ-027 Redirect coincident with imem_ack in FLUSH SHALL load the new redirect_pc into pc and return to REQ.

Reset
REQ-028 reset=1 SHALL on the edge set state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, saved target=0, fetch_count=0.
REQ-029 reset SHALL override all other inputs, including mid-request or in FLUSH; outstanding acks afterwards are ignored per REQ-018.

Configuration
REQ-030 Macro FETCH_CNT_EN defined: fetch_count SHALL increment by 1 (wrapping) on every edge with instr_valid&!stall&!redirect_valid.
REQ-031 Macro FETCH_CNT_EN undefined: fetch_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-032 Reset, memory acks every cycle, stall=0 -> imem_addr 0,4,8,...; instr_valid first high 2 cycles after reset release; instr_pc follows 0,4,8.
REQ-033 instr_valid=1 at pc 0x10, stall=1 for 3 cycles -> instr/instr_pc held, imem_req=0, no pc advance; stall=0 -> 0x14 fetched.
REQ-034 Redirect to 0x100 while imem_req=1, ack delayed 2 cycles -> FLUSH, addr held, data dropped, next request addr 0x100.
REQ-035 Redirect to 0x200 in same cycle as ack -> data discarded, instr_valid=0 next cycle, next imem_addr 0x200.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0; reset asserted in FLUSH -> state IDLE, pc=RESET_PC, instr_valid=0.
REQ-037 FETCH_CNT_EN defined, 5 deliveries with one redirect-squashed cycle -> fetch_count=5; undefined -> fetch_count=0 throughout.
